data_sram_resp: RTL
===================

# data_sram_resp

Data-side SRAM responder for the five-stage CPU: services the data SRAM request the EX stage issues (`data_sram_en/wen/addr/wdata`) and returns `data_sram_rdata`, which the MEM stage consumes one cycle after the access completes. Backed by an internal word array, with byte-lane write enables. A configurable wait-state FSM models slow memory and raises a stall request to the pipeline stall controller while an access is pending. Two 32-bit counters record completed reads and writes for bring-up.

## Interface
- `ADDR_W`, 10: word-address width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 0: extra stall cycles per access; 0 gives plain one-cycle SRAM behaviour.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `data_sram_en` in 1: access request.
- `data_sram_wen` in 4: byte write enables; 4'b0000 with `en`=1 is a read.
- `data_sram_addr` in 32: byte address.
- `data_sram_wdata` in 32: store data, byte i on bits [8i+7:8i].
- `data_sram_rdata` out 32: registered read data.
- `stallreq` out 1: pipeline hold request, combinational.
- `rd_cnt` out 32: completed reads, wraps at 2^32.
- `wr_cnt` out 32: completed writes (any `wen`≠0), wraps at 2^32.

## Operation
- Word index = `addr[ADDR_W+1:2]`. `addr[1:0]` and the bits above ADDR_W+1 are ignored, so high addresses alias.
- Perform step:
  - Write: for each i with `wen[i]`=1, byte i of the word is updated; other bytes are unchanged. `rdata` is unchanged by writes.
  - Read: `rdata` <= the word. `rdata` holds until the next completed read.
- The array contents are not reset.
- FSM states are IDLE and BUSY; there is a down-counter `cnt` with width clog2(WAIT_CYCLES+1), minimum 1.
- WAIT_CYCLES=0: the FSM stays in IDLE. Every cycle with `en`=1 performs at that cycle's edge, using the live inputs. `stallreq` is always 0.
- WAIT_CYCLES>0:
  - IDLE with `en`=0: nothing happens.
  - IDLE with `en`=1: `stallreq`=1. Latch addr/wen/wdata, `cnt`<=WAIT_CYCLES-1, go to BUSY.
  - BUSY with `cnt`≠0: `stallreq`=1, `cnt`<=`cnt`-1.
  - BUSY with `cnt`=0: `stallreq`=0. Perform using the latched fields, then go to IDLE. The request still visible on the inputs this cycle is the same held request and is not re-accepted.
- Inputs are ignored while in BUSY. The requester holds its request stable while `stallreq`=1.
- Counters: `rd_cnt` increments on each read perform, `wr_cnt` on each write perform.

## Timing
- Reset values: `rdata`=0, `rd_cnt`=0, `wr_cnt`=0, state IDLE, `cnt`=0. `stallreq` is forced to 0 while `rst`=1, regardless of `en`.
- Read latency, WAIT_CYCLES=0: request in cycle N, data valid on `rdata` in cycle N+1.
- Read latency, WAIT_CYCLES=W>0:
  - Request first seen in cycle N.
  - `stallreq` is high in cycles N..N+W-1 and low in cycle N+W.
  - Data valid in cycle N+W+1.
- Write commits at the same edge a read would register its data. A read in the very next cycle returns the new bytes.
- Back-to-back requests: the next request is accepted in the first IDLE cycle, at the earliest cycle N+W+1.
- Reset mid-access (asserted in BUSY): the pending access is discarded, the write is not committed, counters return to 0, state goes to IDLE immediately.

## Test plan
- **Plain read/write:** WAIT_CYCLES=0, write 0xDEADBEEF at 0x100 with `wen`=4'hF, then read 0x100 → `rdata`=0xDEADBEEF one cycle after the read; `stallreq` never 1; `wr_cnt`=1, `rd_cnt`=1.
- **Byte lanes:** over 0xDEADBEEF at 0x100, write 0x00001200 with `wen`=4'b0010, then read → 0xDEAD12EF. Also read 0x103 → the same word.
- **Aliasing:** ADDR_W=10, write 0x11111111 at 0x0000_1000, read 0x0000_0000 → 0x11111111.
- **Wait states:** WAIT_CYCLES=3, read request in cycle 5 → `stallreq`=1 in cycles 5–7 and 0 in cycle 8, `rdata` valid in cycle 9. A second request held from cycle 9 is accepted in cycle 9.
- **Reset mid-access:** WAIT_CYCLES=2, write 0xAAAAAAAA at 0x40; assert `rst` in BUSY before the perform cycle; after release, read 0x40 → the prior contents, `wr_cnt`=0 before the read, `stallreq`=0 during reset.
- **Read data hold:** read returns X, then a write to another address, then `en`=0 idles → `rdata` stays X throughout.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word array with byte-lane writes, registered read data, optional wait states.
// Latency 1 cycle (WAIT_CYCLES=0) or WAIT_CYCLES+1; stallreq holds the pipeline while an access is pending.
module data_sram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int CW = ($clog2(WAIT_CYCLES + 1) < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] lat_idx;
  logic [3:0]        lat_wen;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              perform;
  logic [ADDR_W-1:0] p_idx;
  logic [3:0]        p_wen;
  logic [31:0]       p_wdata;
  logic [ADDR_W-1:0] live_idx;
  logic              unused_addr;

  assign live_idx    = data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Without wait states the live request performs directly; otherwise the latched one does.
  always_comb begin
    perform  = 1'b0;
    p_idx    = live_idx;
    p_wen    = data_sram_wen;
    p_wdata  = data_sram_wdata;
    stallreq = 1'b0;
    if (WAIT_CYCLES == 0) begin
      perform = data_sram_en && !rst;
    end else begin
      perform  = !rst && (state == BUSY) && (cnt == '0);
      p_idx    = lat_idx;
      p_wen    = lat_wen;
      p_wdata  = lat_wdata;
      stallreq = !rst && (((state == IDLE) && data_sram_en) ||
                          ((state == BUSY) && (cnt != '0)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wen   <= '0;
      lat_wdata <= '0;
    end else if (WAIT_CYCLES > 0) begin
      case (state)
        IDLE: begin
          if (data_sram_en) begin
            lat_idx   <= live_idx;
            lat_wen   <= data_sram_wen;
            lat_wdata <= data_sram_wdata;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
    end else if (perform) begin
      if (p_wen == 4'b0000) begin
        data_sram_rdata <= mem[p_idx];
        rd_cnt          <= rd_cnt + 32'd1;
      end else begin
        wr_cnt          <= wr_cnt + 32'd1;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (perform) begin
      for (int i = 0; i < 4; i++) begin
        if (p_wen[i]) mem[p_idx][8*i +: 8] <= p_wdata[8*i +: 8];
      end
    end
  end

endmodule
